// File: rtl/kbd_input_arbiter.sv
// Apple-1 keyboard input arbiter. Merges PS/2, UART and text-download ASCII
// sources into one ordered FIFO. Presents the FIFO to the 6502 as the
// KBD (0xD010) / KBDCR (0xD011) register pair.
//
// Ports:
//   clk25, rst_n          25 MHz master clock, async active-low reset
//   enable                CPU clock enable; qualifies the KBD pop
//   cs, address           CPU select of 0xD010..0xD011, ab[0] register select
//   dout                  combinational read data to the CPU data-in mux
//   ps2_valid/ps2_data    one-cycle strobe plus ASCII byte from the PS/2 decoder
//   uart_valid/uart_data  one-cycle strobe plus ASCII byte from UART RX
//   text_valid/text_data  download stream byte (handshaked, never dropped)
//   text_ready            combinational: the text byte is taken this cycle
//   fifo_count            current FIFO occupancy
//   overflow              sticky flag: a PS/2 or UART byte was dropped
module kbd_input_arbiter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          UPCASE     = 1'b1,
    parameter bit          LF_TO_CR   = 1'b1
) (
    input  logic                          clk25,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cs,
    input  logic                          address,
    output logic [7:0]                    dout,
    input  logic                          ps2_valid,
    input  logic [7:0]                    ps2_data,
    input  logic                          uart_valid,
    input  logic [7:0]                    uart_data,
    input  logic                          text_valid,
    input  logic [7:0]                    text_data,
    output logic                          text_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // Strip bit 7, optionally fold lower case and map LF to CR.
    function automatic logic [6:0] xform(input logic [7:0] d);
        logic [6:0] c;
        c = d[6:0];
        if (UPCASE && (c >= 7'h61) && (c <= 7'h7A)) begin
            c = c - 7'h20;
        end
        if (LF_TO_CR && (c == 7'h0A)) begin
            c = 7'h0D;
        end
        return c;
    endfunction

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    last_key;
    logic [6:0]    ps2_hold;
    logic          ps2_hold_valid;
    logic [6:0]    uart_hold;
    logic          uart_hold_valid;
    // Set on the first clock after reset so text_ready stays low while in reset.
    logic          armed;

    logic          full;
    logic          empty;
    logic          push_ps2;
    logic          push_uart;
    logic          push_text;
    logic          push;
    logic [6:0]    push_data;
    logic          pop;
    logic [6:0]    head;

    // Fixed-priority push selection and CPU read decode.
    always_comb begin
        full       = (fifo_count == CW'(FIFO_DEPTH));
        empty      = (fifo_count == '0);
        head       = mem[rd_ptr];
        push_ps2   = !full && ps2_hold_valid;
        push_uart  = !full && !ps2_hold_valid && uart_hold_valid;
        text_ready = armed && !full && !ps2_hold_valid && !uart_hold_valid;
        push_text  = text_valid && text_ready;
        push       = push_ps2 || push_uart || push_text;
        push_data  = xform(text_data);
        if (push_ps2) begin
            push_data = ps2_hold;
        end else if (push_uart) begin
            push_data = uart_hold;
        end
        pop  = cs && enable && !address && !empty;
        dout = 8'h00;
        if (cs) begin
            if (address) begin
                dout = {!empty, 7'b0};
            end else if (empty) begin
                dout = {1'b0, last_key};
            end else begin
                dout = {1'b1, head};
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers and count.
    always_ff @(posedge clk25) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count, last key and the source hold registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            last_key        <= '0;
            ps2_hold        <= '0;
            ps2_hold_valid  <= 1'b0;
            uart_hold       <= '0;
            uart_hold_valid <= 1'b0;
            overflow        <= 1'b0;
            armed           <= 1'b0;
        end else begin
            armed      <= 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                last_key <= head;
            end

            // A strobe into a hold that is draining this edge is not a drop.
            if (ps2_valid) begin
                if (ps2_hold_valid && !push_ps2) begin
                    overflow <= 1'b1;
                end else begin
                    ps2_hold       <= xform(ps2_data);
                    ps2_hold_valid <= 1'b1;
                end
            end else if (push_ps2) begin
                ps2_hold_valid <= 1'b0;
            end

            if (uart_valid) begin
                if (uart_hold_valid && !push_uart) begin
                    overflow <= 1'b1;
                end else begin
                    uart_hold       <= xform(uart_data);
                    uart_hold_valid <= 1'b1;
                end
            end else if (push_uart) begin
                uart_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_input_arbiter.sv
// Self-checking bench for kbd_input_arbiter: table of single-byte transform
// vectors plus hand-written sequences for priority, full and reset cases.
module tb_kbd_input_arbiter;

    logic       clk25;
    logic       rst_n;
    logic       enable;
    logic       cs;
    logic       address;
    logic [7:0] dout;
    logic       ps2_valid;
    logic [7:0] ps2_data;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       text_valid;
    logic [7:0] text_data;
    logic       text_ready;
    logic [4:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    kbd_input_arbiter #(.FIFO_DEPTH(16), .UPCASE(1'b1), .LF_TO_CR(1'b1)) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .enable     (enable),
        .cs         (cs),
        .address    (address),
        .dout       (dout),
        .ps2_valid  (ps2_valid),
        .ps2_data   (ps2_data),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .text_valid (text_valid),
        .text_data  (text_data),
        .text_ready (text_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         src;   // 0 = PS/2, 1 = UART, 2 = text
        logic [7:0] din;
        logic [7:0] exp;   // expected KBD read while the byte is queued
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; DUT samples on the rising edge.
    task automatic tick();
        @(posedge clk25);
        @(negedge clk25);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        cs = 1'b1; address = 1'b0; enable = 1'b1;
        #1;
        check(name, dout, exp);
        tick();
        cs = 1'b0; enable = 1'b0;
    endtask

    logic [7:0] e;
    int         accepted;

    initial begin
        vecs[0] = '{0, 8'h61, 8'hC1};
        vecs[1] = '{0, 8'h7A, 8'hDA};
        vecs[2] = '{0, 8'h60, 8'hE0};
        vecs[3] = '{0, 8'h7B, 8'hFB};
        vecs[4] = '{1, 8'h0A, 8'h8D};
        vecs[5] = '{1, 8'h8A, 8'h8D};
        vecs[6] = '{1, 8'hE1, 8'hC1};
        vecs[7] = '{1, 8'h00, 8'h80};
        vecs[8] = '{2, 8'h0A, 8'h8D};
        vecs[9] = '{2, 8'hFA, 8'hDA};

        rst_n = 1'b0; enable = 1'b0; cs = 1'b0; address = 1'b0;
        ps2_valid = 1'b0; ps2_data = 8'h00; uart_valid = 1'b0; uart_data = 8'h00;
        text_valid = 1'b0; text_data = 8'h00;

        // Reset state.
        @(negedge clk25);
        @(negedge clk25);
        cs = 1'b1; address = 1'b1; #1;
        check("rst_kbdcr", dout, 8'h00);
        address = 1'b0; #1;
        check("rst_kbd", dout, 8'h00);
        check("rst_count", fifo_count, 5'd0);
        check("rst_ready", text_ready, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        cs = 1'b0;
        rst_n = 1'b1; #1;
        check("ready_before_clk", text_ready, 1'b0);
        tick();
        check("ready_after_rst", text_ready, 1'b1);

        // Single-byte transform table.
        for (int i = 0; i < 10; i++) begin
            case (vecs[i].src)
                0: begin
                    ps2_valid = 1'b1; ps2_data = vecs[i].din; tick();
                    ps2_valid = 1'b0; tick();
                end
                1: begin
                    uart_valid = 1'b1; uart_data = vecs[i].din; tick();
                    uart_valid = 1'b0; tick();
                end
                default: begin
                    text_valid = 1'b1; text_data = vecs[i].din; tick();
                    text_valid = 1'b0;
                end
            endcase
            #1;
            check($sformatf("vec%0d_count", i), fifo_count, 5'd1);
            cs = 1'b1; address = 1'b1; #1;
            check($sformatf("vec%0d_kbdcr", i), dout, 8'h80);
            pop_expect($sformatf("vec%0d_kbd", i), vecs[i].exp);
            #1;
            check($sformatf("vec%0d_count_after", i), fifo_count, 5'd0);
            cs = 1'b1; address = 1'b1; #1;
            check($sformatf("vec%0d_kbdcr_empty", i), dout, 8'h00);
            address = 1'b0; #1;
            e = vecs[i].exp & 8'h7F;
            check($sformatf("vec%0d_last_key", i), dout, e);
            cs = 1'b0;
        end

        // PS/2 and UART strobed together, text stalled behind both holds.
        ps2_valid = 1'b1; ps2_data = 8'h31; uart_valid = 1'b1; uart_data = 8'h32;
        tick();
        ps2_valid = 1'b0; uart_valid = 1'b0;
        text_valid = 1'b1; text_data = 8'h0A; #1;
        check("prio_ready_c1", text_ready, 1'b0);
        tick(); #1;
        check("prio_ready_c2", text_ready, 1'b0);
        tick(); #1;
        check("prio_ready_c3", text_ready, 1'b1);
        tick();
        text_valid = 1'b0; #1;
        check("prio_count", fifo_count, 5'd3);
        pop_expect("prio_pop0", 8'hB1);
        pop_expect("prio_pop1", 8'hB2);
        pop_expect("prio_pop2", 8'h8D);
        cs = 1'b1; address = 1'b0; #1;
        check("prio_empty_kbd", dout, 8'h0D);
        cs = 1'b0;

        // Back-to-back PS/2 strobes: the second lands while the first drains.
        ps2_valid = 1'b1; ps2_data = 8'h41; tick();
        ps2_data = 8'h42; tick();
        ps2_valid = 1'b0; tick(); #1;
        check("b2b_count", fifo_count, 5'd2);
        check("b2b_ovf", overflow, 1'b0);
        pop_expect("b2b_pop0", 8'hC1);
        pop_expect("b2b_pop1", 8'hC2);

        // Text stream into a 16-deep FIFO with no pops.
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 16; c++) begin
            text_valid = 1'b1; text_data = 8'(8'h41 + accepted); #1;
            if (text_ready) accepted++;
            tick();
        end
        text_data = 8'(8'h41 + accepted); #1;
        check("stream_accepted", accepted, 16);
        check("stream_full_count", fifo_count, 5'd16);
        check("stream_full_ready", text_ready, 1'b0);
        tick(); #1;
        check("stream_still_full", fifo_count, 5'd16);
        pop_expect("stream_pop0", 8'hC1);
        #1;
        check("stream_after_pop_count", fifo_count, 5'd15);
        check("stream_after_pop_ready", text_ready, 1'b1);
        check("stream_next_byte", text_data, 8'h51);
        tick();
        text_valid = 1'b0; #1;
        check("stream_refill_count", fifo_count, 5'd16);
        check("stream_ovf", overflow, 1'b0);

        // UART strobes against a full FIFO: first held, second dropped.
        uart_valid = 1'b1; uart_data = 8'h35; tick();
        uart_data = 8'h36; tick();
        uart_valid = 1'b0; #1;
        check("full_ovf", overflow, 1'b1);
        check("full_count", fifo_count, 5'd16);
        for (int k = 0; k < 16; k++) begin
            pop_expect($sformatf("drain%0d", k), 8'(8'hC2 + k));
        end
        pop_expect("drain_uart", 8'hB5);
        #1;
        check("drain_empty_count", fifo_count, 5'd0);
        cs = 1'b1; address = 1'b0; #1;
        check("drain_empty_kbd", dout, 8'h35);
        cs = 1'b0;
        check("drain_ovf_sticky", overflow, 1'b1);

        // No pop without enable; KBDCR reads have no side effect.
        ps2_valid = 1'b1; ps2_data = 8'h37; tick();
        ps2_valid = 1'b0; tick();
        cs = 1'b1; address = 1'b0; enable = 1'b0; tick(); #1;
        check("noen_count", fifo_count, 5'd1);
        check("noen_kbd", dout, 8'hB7);
        address = 1'b1; enable = 1'b1; tick(); #1;
        check("kbdcr_read_count", fifo_count, 5'd1);
        check("kbdcr_read_val", dout, 8'h80);
        cs = 1'b0; enable = 1'b0;

        // Asynchronous reset during a download.
        text_valid = 1'b1; text_data = 8'h48; tick();
        text_data = 8'h49; tick();
        #5 rst_n = 1'b0; #1;
        check("async_rst_count", fifo_count, 5'd0);
        check("async_rst_ready", text_ready, 1'b0);
        check("async_rst_ovf", overflow, 1'b0);
        tick(); #1;
        check("in_rst_ready", text_ready, 1'b0);
        text_valid = 1'b0;
        rst_n = 1'b1;
        tick(); #1;
        check("post_rst_ready", text_ready, 1'b1);
        check("post_rst_count", fifo_count, 5'd0);
        cs = 1'b1; address = 1'b0; #1;
        check("post_rst_kbd", dout, 8'h00);
        cs = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_input_arbiter.md
Name: kbd_input_arbiter

Overview:
Merges ASCII key sources (PS/2 decoder, UART RX, text-file download stream) into one ordered FIFO and presents it to the 6502 as the Apple-1 keyboard register pair at 0xD010 (KBD) / 0xD011 (KBDCR). Replaces the per-source chip-select priority in the data-in mux with a single arbitrated, lossless-where-possible input path. Sits between the peripherals and the CPU data-in mux, clocked from the 25 MHz master clock and qualified by the CPU clock enable.

Parameters:
FIFO_DEPTH, 16, entries in key FIFO; power of 2, minimum 2
UPCASE, 1, 1 = fold 'a'..'z' (0x61..0x7A) to upper case before enqueue
LF_TO_CR, 1, 1 = map 0x0A to 0x0D before enqueue

Ports:
clk25  input  1  25 MHz master clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  CPU clock enable (cpu_clken); qualifies CPU reads
cs  input  1  CPU selects 0xD010..0xD011
address  input  1  ab[0]: 0 = KBD, 1 = KBDCR
dout  output  8  read data to CPU mux
ps2_valid  input  1  one-cycle strobe, ps2_data valid
ps2_data  input  8  ASCII from PS/2 decoder
uart_valid  input  1  one-cycle strobe, uart_data valid
uart_data  input  8  ASCII from UART RX
text_valid  input  1  text download byte available
text_data  input  8  text download byte
text_ready  output  1  arbiter accepts text byte this cycle
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: a PS/2 or UART byte was dropped

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, hold registers invalid, last_key = 0, overflow = 0, text_ready = 0, fifo_count = 0.
- Input staging: PS/2 and UART each have a 1-entry hold register (7-bit data + valid). On *_valid strobe: if hold empty, capture data[6:0]; if hold full, drop byte, set overflow (sticky until reset). Strobe and drain of the same hold in one cycle: drain old, capture new, no drop.
- Transform applied when staged (PS/2, UART) or on acceptance (text): bit7 discarded; UPCASE fold (subtract 0x20); LF_TO_CR map. No other codes altered; 0x00 is stored.
- Arbitration, every clk25 cycle (not gated by enable): full = (count == FIFO_DEPTH) on pre-edge count. If !full, push at most one byte, fixed priority: PS/2 hold > UART hold > text stream. Pushed hold is invalidated on that edge.
- text_ready = !full & !ps2_hold_valid & !uart_hold_valid (combinational). Text transfer occurs iff text_valid & text_ready; text source is never dropped, only stalled.
- CPU read, combinational dout while cs:
  - address 0: empty ? {1'b0, last_key} : {1'b1, head}.
  - address 1: {~empty, 7'b0}.
  - cs low: dout = 8'h00.
- Pop: on edge where cs & enable & !address & !empty; head copied to last_key, read pointer advances. Reads of KBDCR, and reads of KBD when empty, have no side effect. CPU writes are ignored (no we port).
- Simultaneous push and pop: both take effect; count = count + push - pop. Full-state decision uses pre-edge count, so a push is not granted on the same edge that a pop frees a full FIFO.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count distinguishes full from empty.
- Ordering: bytes leave in push order; each source's bytes keep their relative order.
- Reset mid-download: text_ready drops immediately and stays low until rst_n deasserts; queued bytes are discarded.

Test Plan:
- Reset then read KBDCR/KBD with cs=1, address=1/0 -> dout 8'h00 / 8'h00; text_ready 1 one cycle after rst_n high.
- Single PS/2 strobe data 8'h61 -> fifo_count 1, KBDCR 8'h80, KBD read 8'hC1; after pop KBDCR 8'h00, KBD 8'h41.
- PS/2 8'h31 and UART 8'h32 strobed in the same cycle with text_valid=1, text_data 8'h0A -> pops yield 8'hB1, 8'hB2, 8'h8D; text_ready low until both holds drain.
- Stream 20 text bytes 0x41..0x54 with no pops, depth 16 -> text_ready low after 16 accepted, fifo_count 16; pop one -> next edge text_ready high, byte 0x51 accepted; overflow stays 0.
- FIFO full, two UART strobes 8'h35, 8'h36 without pops -> first held, second dropped, overflow 1; after pops, 8'hB5 appears and 8'hB6 never does.
- Pop with enable=0 -> no pointer change; assert rst_n low mid-stream -> fifo_count 0, text_ready 0 asynchronously.
